// File: rtl/axi_fifo_o_reader.sv
// axi_fifo_o_reader: drains a fixed-latency output FIFO into a valid/ready video stream
// with a small skid buffer and per-line / per-frame word counters.
module axi_fifo_o_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 1,
    parameter int LINE_WORDS  = 480,
    parameter int FRAME_LINES = 1080
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_sof,
    output logic [11:0]           word_cnt,
    output logic [11:0]           line_cnt
);
    localparam int DEPTH = RD_LATENCY + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         occ, infl_cnt;
    logic [RD_LATENCY-1:0] infl;
    logic [CW:0]           load;
    logic                  cap, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign cap     = infl[RD_LATENCY-1];
    assign m_valid = occ != '0;
    assign pop     = m_valid && m_ready;
    assign m_data  = mem[head];
    assign m_last  = m_valid && word_cnt == 12'(LINE_WORDS - 1);
    assign m_sof   = m_valid && word_cnt == '0 && line_cnt == '0;
    // A pop on this edge frees a slot, so a read may be issued into it without a bubble.
    assign load       = (CW+1)'(occ) + (CW+1)'(infl_cnt) - (CW+1)'(pop);
    assign fifo_rd_en = !fifo_rd_empty && !flush && !rd_rst && load < (CW+1)'(DEPTH);

    always_ff @(posedge rd_clk) begin
        if (rd_rst || flush) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            infl     <= '0;
            infl_cnt <= '0;
            word_cnt <= '0;
            line_cnt <= '0;
        end else begin
            infl     <= (infl << 1) | RD_LATENCY'(fifo_rd_en);
            infl_cnt <= infl_cnt + CW'(fifo_rd_en) - CW'(cap);
            occ      <= occ + CW'(cap) - CW'(pop);
            if (cap)
                tail <= nxt(tail);
            if (pop) begin
                head     <= nxt(head);
                word_cnt <= m_last ? '0 : word_cnt + 1'b1;
                if (m_last)
                    line_cnt <= line_cnt == 12'(FRAME_LINES - 1) ? '0 : line_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (cap)
            mem[tail] <= fifo_rd_data;
    end
endmodule

// File: tb/tb_axi_fifo_o_reader.sv
// tb_axi_fifo_o_reader: two instances (read latency 1 and 2) fed by a FIFO model;
// words read from the model are queued and compared as the stream pops them.
module tb_axi_fifo_o_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en [2], empty [2], flush [2], hold [2];
    logic        m_valid [2], m_ready [2], m_last [2], m_sof [2];
    logic [15:0] rd_data [2], m_data [2], d1 [2], d2 [2];
    logic [11:0] wc [2], lc [2];
    int          loaded [2], taken [2], seq [2];
    logic [15:0] q0 [$], q1 [$];
    int          checks = 0, passes = 0;

    for (genvar g = 0; g < 2; g++) begin : du
        axi_fifo_o_reader #(
            .DATA_WIDTH(16), .RD_LATENCY(g + 1), .LINE_WORDS(4), .FRAME_LINES(2)
        ) dut (
            .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en[g]), .fifo_rd_data(rd_data[g]),
            .fifo_rd_empty(empty[g]), .flush(flush[g]), .m_data(m_data[g]), .m_valid(m_valid[g]),
            .m_ready(m_ready[g]), .m_last(m_last[g]), .m_sof(m_sof[g]), .word_cnt(wc[g]),
            .line_cnt(lc[g])
        );
        assign empty[g] = hold[g] || loaded[g] == taken[g];
    end
    assign rd_data[0] = d1[0];
    assign rd_data[1] = d2[1];

    // FIFO model plus scoreboard: issued reads are pushed, popped words retired, flush/reset discard.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst || flush[g]) begin
                if (g == 0) q0.delete(); else q1.delete();
            end else begin
                if (m_valid[g] && m_ready[g]) begin
                    if (g == 0 && q0.size() > 0) void'(q0.pop_front());
                    if (g == 1 && q1.size() > 0) void'(q1.pop_front());
                end
                if (rd_en[g]) begin
                    if (g == 0) q0.push_back(16'(seq[g])); else q1.push_back(16'(seq[g]));
                end
            end
            if (rd_en[g]) begin
                d1[g]    <= 16'(seq[g]);
                seq[g]   <= seq[g] + 1;
                taken[g] <= taken[g] + 1;
            end
            d2[g] <= d1[g];
        end
    end

    function automatic int qsize(input int g);
        return g == 0 ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] qhead(input int g);
        if (qsize(g) == 0) return 16'hxxxx;
        return g == 0 ? q0[0] : q1[0];
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                checks++; if (rd_en[g] !== 1'b0) $display("FAIL reset_rd_en[%0d]: got %b want 0", g, rd_en[g]); else passes++;
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({m_valid[g], m_last[g], m_sof[g], wc[g], lc[g]} !== 27'd0)
                $display("FAIL reset_state[%0d]: got v%b l%b s%b w%0d l%0d want all 0", g, m_valid[g], m_last[g], m_sof[g], wc[g], lc[g]);
            else passes++;
        end
    endtask

    task automatic test_stream;
        int base;
        base = seq[0];
        m_ready[0] = 1'b1;
        loaded[0] += 10;
        #1;
        checks++; if (rd_en[0] !== 1'b1) $display("FAIL stream_first_rd: got %b want 1", rd_en[0]); else passes++;
        @(negedge clk);
        checks++; if (m_valid[0] !== 1'b0) $display("FAIL stream_latency: got valid %b want 0", m_valid[0]); else passes++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({m_valid[0], m_data[0]} !== {1'b1, 16'(base + i)})
                $display("FAIL stream_word%0d: got v%b %0d want v1 %0d", i, m_valid[0], m_data[0], base + i);
            else passes++;
        end
        @(negedge clk);
        checks++; if (m_valid[0] !== 1'b0) $display("FAIL stream_end: got valid %b want 0", m_valid[0]); else passes++;
    endtask

    task automatic test_backpressure;
        int base, cnt, k;
        logic stable;
        base = seq[1];
        cnt = 0;
        stable = 1'b1;
        m_ready[1] = 1'b0;
        loaded[1] += 10;
        for (int i = 0; i < 20; i++) begin
            #1;
            cnt += int'(rd_en[1]);
            if (i >= 10 && (m_data[1] !== 16'(base) || m_sof[1] !== 1'b1 || m_last[1] !== 1'b0)) stable = 1'b0;
            @(negedge clk);
        end
        checks++; if (cnt != 3) $display("FAIL bp_reads: got %0d want 3", cnt); else passes++;
        checks++; if ({m_valid[1], m_data[1]} !== {1'b1, 16'(base)}) $display("FAIL bp_head: got v%b %0d want v1 %0d", m_valid[1], m_data[1], base); else passes++;
        checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b want 1", stable); else passes++;
        m_ready[1] = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            if (m_valid[1]) begin
                checks++; if (m_data[1] !== 16'(base + k)) $display("FAIL bp_word%0d: got %0d want %0d", k, m_data[1], base + k); else passes++;
                k++;
            end
            @(negedge clk);
        end
        checks++; if (k != 10) $display("FAIL bp_count: got %0d want 10", k); else passes++;
    endtask

    task automatic test_framing;
        int base, k;
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        base = seq[0];
        m_ready[0] = 1'b1;
        loaded[0] += 16;
        k = 0;
        for (int c = 0; c < 80 && k < 16; c++) begin
            if (m_valid[0]) begin
                checks++;
                if ({m_data[0], m_last[0], m_sof[0], wc[0], lc[0]} !== {16'(base + k), k % 4 == 3, k % 8 == 0, 12'(k % 4), 12'((k / 4) % 2)})
                    $display("FAIL frame_word%0d: got d%0d last%b sof%b w%0d l%0d want d%0d last%b sof%b w%0d l%0d", k,
                             m_data[0], m_last[0], m_sof[0], wc[0], lc[0], base + k, k % 4 == 3, k % 8 == 0, k % 4, (k / 4) % 2);
                else passes++;
                k++;
            end
            @(negedge clk);
        end
        checks++; if (k != 16) $display("FAIL frame_count: got %0d want 16", k); else passes++;
    endtask

    task automatic test_flush;
        int base;
        m_ready[1] = 1'b0;
        loaded[1] += 1;
        #1;
        checks++; if (rd_en[1] !== 1'b1) $display("FAIL flush_rd: got %b want 1", rd_en[1]); else passes++;
        @(negedge clk);
        flush[1] = 1'b1;
        @(negedge clk);
        flush[1] = 1'b0;
        checks++; if ({m_valid[1], wc[1], lc[1]} !== 25'd0) $display("FAIL flush_clear: got v%b w%0d l%0d want 0 0 0", m_valid[1], wc[1], lc[1]); else passes++;
        @(negedge clk);
        checks++; if (m_valid[1] !== 1'b0) $display("FAIL flush_discard: got valid %b want 0", m_valid[1]); else passes++;
        base = seq[1];
        loaded[1] += 1;
        m_ready[1] = 1'b1;
        for (int c = 0; c < 10 && m_valid[1] !== 1'b1; c++) @(negedge clk);
        checks++;
        if ({m_valid[1], m_sof[1], m_data[1]} !== {2'b11, 16'(base)})
            $display("FAIL flush_next: got v%b sof%b %0d want v1 sof1 %0d", m_valid[1], m_sof[1], m_data[1], base);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int g = 0; g < 2; g++) loaded[g] += 20000;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (m_valid[g]) begin
                    checks++; if (m_data[g] !== qhead(g)) $display("FAIL rand_order[%0d]: got %0d want %0d", g, m_data[g], qhead(g)); else passes++;
                end
                checks++; if (qsize(g) > g + 2) $display("FAIL rand_occupancy[%0d]: got %0d want <= %0d", g, qsize(g), g + 2); else passes++;
                m_ready[g] = 1'($urandom_range(0, 1));
                hold[g] = $urandom_range(0, 3) == 0;
            end
            #1;
            for (int g = 0; g < 2; g++) begin
                checks++; if (rd_en[g] && empty[g]) $display("FAIL rand_rd_when_empty[%0d]: got rd_en 1 want 0", g); else passes++;
            end
        end
        for (int g = 0; g < 2; g++) begin
            m_ready[g] = 1'b1;
            hold[g] = 1'b0;
            loaded[g] = taken[g];
        end
        repeat (10) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (m_valid[g]) begin
                    checks++; if (m_data[g] !== qhead(g)) $display("FAIL drain_order[%0d]: got %0d want %0d", g, m_data[g], qhead(g)); else passes++;
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            checks++; if (m_valid[g] !== 1'b0 || qsize(g) != 0) $display("FAIL drain_empty[%0d]: got v%b pending %0d want v0 pending 0", g, m_valid[g], qsize(g)); else passes++;
        end
    endtask

    task automatic test_reset_mid;
        m_ready[1] = 1'b0;
        loaded[1] += 10;
        repeat (6) @(negedge clk);
        checks++; if (m_valid[1] !== 1'b1 || qsize(1) != 3) $display("FAIL mid_buffered: got v%b pending %0d want v1 pending 3", m_valid[1], qsize(1)); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (rd_en[1] !== 1'b0) $display("FAIL mid_rd_en_a: got %b want 0", rd_en[1]); else passes++;
        @(negedge clk);
        checks++; if (rd_en[1] !== 1'b0) $display("FAIL mid_rd_en_b: got %b want 0", rd_en[1]); else passes++;
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid[1], m_last[1], m_sof[1], wc[1], lc[1]} !== 27'd0)
            $display("FAIL mid_cleared: got v%b l%b s%b w%0d l%0d want all 0", m_valid[1], m_last[1], m_sof[1], wc[1], lc[1]);
        else passes++;
        @(negedge clk);
        checks++; if (m_valid[1] !== 1'b0) $display("FAIL mid_no_stale: got valid %b want 0", m_valid[1]); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            flush[g] = 1'b0;
            hold[g] = 1'b0;
            m_ready[g] = 1'b0;
            loaded[g] = 0;
            taken[g] = 0;
            seq[g] = 0;
        end
        test_reset;
        test_stream;
        test_backpressure;
        test_framing;
        test_flush;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
